// File: rtl/byte_serial_add_ctrl_if.sv
// Operand/result bundle between an add requester (master) and byte_serial_add_ctrl (slave).
// The sub signal exists only when BYTE_SERIAL_SUB_EN is defined.
interface byte_serial_add_ctrl_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
`ifdef BYTE_SERIAL_SUB_EN
  logic                  sub;
`endif
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;

  // start is taken whenever busy is low (IDLE or DONE); operands are sampled
  // only on that accepting edge. done is a one-cycle pulse; sum/cout hold afterwards.
  modport master (
`ifdef BYTE_SERIAL_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef BYTE_SERIAL_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial 32-bit adder: one shared 8-bit ripple adder stepped LSB-first over NBYTES cycles.
// Optional BYTE_SERIAL_SUB_EN adds a sub input that turns the operation into a-b.
module eightbitadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c,
  output logic [7:0] sum,
  output logic       carry
);
  logic [8:0] cc;

  assign cc[0] = c;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ cc[i];
    assign cc[i+1]  = (a[i] & b[i]) | (cc[i] & (a[i] ^ b[i]));
  end
  assign carry = cc[8];
endmodule

module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_serial_add_ctrl_if.slave bus,
  output logic [1:0]           dbg_state
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  logic [7:0]      add_a, add_b, add_sum;
  logic            add_carry;
  logic [W-1:0]    b_load;
  logic            cin_load;
  logic [IW+2:0]   lsb;

  assign lsb   = {idx_q, 3'b000};
  assign add_a = a_q[lsb +: 8];
  assign add_b = b_q[lsb +: 8];

  eightbitadder u_add (
    .a     (add_a),
    .b     (add_b),
    .c     (carry_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Subtract is a + ~b + 1, so only the loaded operand and byte-0 carry change.
  always_comb begin
`ifdef BYTE_SERIAL_SUB_EN
    b_load   = bus.sub ? ~bus.b : bus.b;
    cin_load = bus.sub | bus.cin;
`else
    b_load   = bus.b;
    cin_load = bus.cin;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_RUN: begin
        sum_d[lsb +: 8] = add_sum;
        carry_d         = add_carry;
        idx_d           = idx_q + IW'(1);
        if (idx_q == IW'(NBYTES - 1)) begin
          cout_d  = add_carry;
          state_d = S_DONE;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_load;
          carry_d = cin_load;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign dbg_state = state_q;
endmodule
